store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Sits directly downstream of the STRSP / store address ALUs.
- Accepts store requests carrying an address and write data, and holds them in a small in-order FIFO.
- Drains the FIFO to data memory over a req/ack handshake.
- Gives the load path combinational store-to-load forwarding, so a load sees pending stores before they reach memory.

Parameters:
- DEPTH, 4, number of buffered stores; must be a power of 2, minimum 2.
- WIDTH, 16, address and data width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- stValid  input  1  store request valid from the store ALU stage.
- stAddress  input  WIDTH  store address (sign-extended immediate + SP, already computed upstream).
- stData  input  WIDTH  store write data.
- stReady  output  1  buffer can accept a store this cycle.
- memReq  output  1  write request to data memory.
- memAddress  output  WIDTH  address of the head entry.
- memWriteData  output  WIDTH  data of the head entry.
- memAck  input  1  memory accepted the head write this cycle.
- ldAddress  input  WIDTH  address of the load currently being executed.
- ldHit  output  1  ldAddress matches at least one buffered store.
- ldData  output  WIDTH  data of the youngest matching buffered store.
- count  output  $clog2(DEPTH)+1  number of valid entries.
- empty  output  1  count == 0.

Behaviour:
- Storage: circular FIFO with head and tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH, plus a per-entry valid bit and a count register.
- Reset (asynchronous, effective immediately):
  - head, tail and count go to 0; all valid bits clear.
  - Outputs then read stReady=1, memReq=0, ldHit=0, empty=1, count=0, memAddress=memWriteData=ldData=0.
  - Reset during a pending memory write drops memReq immediately; that entry is discarded, not retried.
- Enqueue:
  - Occurs when stValid && stReady at the rising edge.
  - Writes {stAddress, stData} at tail, sets its valid bit, and advances tail.
  - stReady = (count != DEPTH). It does not look ahead to a same-cycle dequeue, so a full buffer refuses a store even when memAck pops in that cycle.
  - stValid while stReady=0 is ignored; upstream must hold or stall.
- Drain:
  - memReq = !empty. memAddress and memWriteData come combinationally from the head entry and stay stable until acknowledged.
  - When memReq && memAck at the rising edge: clear the head valid bit, advance head, decrement count.
  - memAck while memReq=0 is ignored.
  - At most one write completes per cycle.
  - memAddress and memWriteData are 0 when empty.
- Simultaneous enqueue and dequeue: both take effect and count is unchanged.
- Enqueue into an empty buffer: memReq asserts in the following cycle. No same-cycle bypass to memory.
- Forwarding:
  - Purely combinational, over current valid entries only. A store being enqueued in the same cycle is not visible.
  - ldHit=1 if any valid entry's address equals ldAddress.
  - ldData is the data of the youngest match, i.e. nearest to tail in age order, not by physical index. Age order must be correct across pointer wrap-around.
  - The head entry being acked this cycle still forwards during that cycle.
  - ldHit=0 implies ldData=0.
- Arithmetic:
  - Addresses are compared on all WIDTH bits exactly, with no masking.
  - count must never exceed DEPTH or underflow below 0.

Test Plan:
- Reset, then hold memAck=0 and issue 4 stores to addresses 0x0010..0x0013 with data 0xA0..0xA3 → stReady=0 and count=4 after the 4th; a 5th store (0x0014) is not accepted; memReq=1, memAddress=0x0010, memWriteData=0xA0 held stable.
- Full buffer, then drive stValid and memAck in the same cycle → only the pop occurs and count=3. Next cycle, store and ack together → count stays 3; drain order is 0x0011, 0x0012, 0x0013, new entry.
- Stores to 0x0020/0x1111 then 0x0020/0x2222, with ldAddress=0x0020 → ldHit=1, ldData=0x2222. After acking the first store, ldData is still 0x2222. With ldAddress=0x0021 → ldHit=0, ldData=0.
- Wrap-around: cycle 6 stores through with single acks so tail wraps; place older 0x0030/0x0001 at a high index and younger 0x0030/0x0002 at index 0 → ldData=0x0002.
- Assert reset asynchronously mid-cycle with 2 entries and memReq=1 → memReq, count and ldHit go to 0 before the next clock edge; after release, empty=1 and a memAck pulse has no effect.
- Spurious memAck while empty → count stays 0 and no pointer movement (check head/tail via a subsequent store draining at the correct address).

Source files
------------

// File: rtl/store_buffer_if.sv
// Store buffer bus: the store request side, the data-memory drain side and
// the load forwarding port, bundled so both ends share one declaration.
interface store_buffer_if #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Store request from the store address ALU stage
  logic             stValid;
  logic [WIDTH-1:0] stAddress;
  logic [WIDTH-1:0] stData;
  logic             stReady;

  // Drain to data memory
  logic             memReq;
  logic [WIDTH-1:0] memAddress;
  logic [WIDTH-1:0] memWriteData;
  logic             memAck;

  // Load forwarding
  logic [WIDTH-1:0] ldAddress;
  logic             ldHit;
  logic [WIDTH-1:0] ldData;

  // Occupancy
  logic [CW-1:0]    count;
  logic             empty;

  // The buffer itself
  modport slave (
    input  stValid, stAddress, stData, memAck, ldAddress,
    output stReady, memReq, memAddress, memWriteData, ldHit, ldData,
           count, empty
  );

  // Whoever drives the buffer (pipeline + memory + load unit)
  modport master (
    output stValid, stAddress, stData, memAck, ldAddress,
    input  stReady, memReq, memAddress, memWriteData, ldHit, ldData,
           count, empty
  );
endinterface

// File: rtl/store_buffer.sv
// In-order store buffer: queues {address, data} stores, drains them to data
// memory over req/ack, and forwards the youngest matching store to loads.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  store_buffer_if.slave bus
);
  localparam int            PW   = $clog2(DEPTH);
  localparam int            CW   = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] addr_q [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;

  logic             empty;
  logic             ready;
  logic             push;
  logic             pop;
  logic             fwd_hit;
  logic [WIDTH-1:0] fwd_data;

  // Readiness ignores a same-cycle pop so the ready path stays off memAck.
  assign empty = (count_q == '0);
  assign ready = (count_q != FULL);
  assign push  = bus.stValid && ready;
  assign pop   = !empty && bus.memAck;

  // -------------------------------------------------------------------------
  // Control state: pointers, valid bits, occupancy
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values regardless of statement order in the block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      // push and pop never hit the same slot: equal pointers mean empty or full
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PW'(1);
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Entry payload storage
  // -------------------------------------------------------------------------
  // NOTE: the payload array has no reset on purpose; every read is qualified
  // by a valid bit or by empty, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= bus.stAddress;
      data_q[tail_q] <= bus.stData;
    end
  end

  // -------------------------------------------------------------------------
  // Store-to-load forwarding
  // -------------------------------------------------------------------------
  // Walk entries oldest-to-youngest starting at head, so a later match simply
  // overrides an earlier one and pointer wrap is handled by the modulo add.
  // NOTE: every variable assigned here gets a default first so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (valid_q[idx] && (addr_q[idx] == bus.ldAddress)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.stReady      = ready;
  assign bus.memReq       = !empty;
  assign bus.memAddress   = empty ? '0 : addr_q[head_q];
  assign bus.memWriteData = empty ? '0 : data_q[head_q];
  assign bus.ldHit        = fwd_hit;
  assign bus.ldData       = fwd_data;
  assign bus.count        = count_q;
  assign bus.empty        = empty;

  // -------------------------------------------------------------------------
  // Structural invariants
  // -------------------------------------------------------------------------
  a_count_bound : assert property (@(posedge clk) disable iff (reset)
    count_q <= FULL);

  a_valid_matches_count : assert property (@(posedge clk) disable iff (reset)
    32'($countones(valid_q)) == 32'(count_q));

  a_no_overwrite : assert property (@(posedge clk) disable iff (reset)
    !(push && valid_q[tail_q]));

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a table of per-cycle vectors with
// hand-computed outputs, then hand-written reset and spurious-ack sequences.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic reset;

  int checks = 0;
  int errors = 0;

  store_buffer_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  store_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Inputs applied in a cycle and the outputs expected before that cycle's edge
  typedef struct {
    logic        st_valid;
    logic [15:0] st_addr;
    logic [15:0] st_data;
    logic        ack;
    logic [15:0] ld_addr;
    logic        ready;
    logic        req;
    logic [15:0] maddr;
    logic [15:0] mdata;
    logic        hit;
    logic [15:0] ldata;
    logic [2:0]  count;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sv, input logic [15:0] sa,
                       input logic [15:0] sd, input logic ack,
                       input logic [15:0] la);
    bus.stValid   = sv;
    bus.stAddress = sa;
    bus.stData    = sd;
    bus.memAck    = ack;
    bus.ldAddress = la;
  endtask

  initial begin
    //          stV   stAddr    stData    ack   ldAddr    rdy   req   mAddr     mData     hit   ldData    cnt
    // Fill to full with memAck low; fifth store refused
    vecs[0]  = '{1'b1, 16'h0010, 16'h00A0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 3'd0};
    vecs[1]  = '{1'b1, 16'h0011, 16'h00A1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 16'h00A0, 1'b0, 16'h0000, 3'd1};
    vecs[2]  = '{1'b1, 16'h0012, 16'h00A2, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 16'h00A0, 1'b0, 16'h0000, 3'd2};
    vecs[3]  = '{1'b1, 16'h0013, 16'h00A3, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 16'h00A0, 1'b0, 16'h0000, 3'd3};
    vecs[4]  = '{1'b1, 16'h0014, 16'h00A4, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0010, 16'h00A0, 1'b0, 16'h0000, 3'd4};
    vecs[5]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0013, 1'b0, 1'b1, 16'h0010, 16'h00A0, 1'b1, 16'h00A3, 3'd4};
    // Full + store + ack: only the pop; then store + ack keeps count at 3
    vecs[6]  = '{1'b1, 16'h0015, 16'h00A5, 1'b1, 16'h0000, 1'b0, 1'b1, 16'h0010, 16'h00A0, 1'b0, 16'h0000, 3'd4};
    vecs[7]  = '{1'b1, 16'h0016, 16'h00A6, 1'b1, 16'h0000, 1'b1, 1'b1, 16'h0011, 16'h00A1, 1'b0, 16'h0000, 3'd3};
    vecs[8]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0015, 1'b1, 1'b1, 16'h0012, 16'h00A2, 1'b0, 16'h0000, 3'd3};
    vecs[9]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0016, 1'b1, 1'b1, 16'h0013, 16'h00A3, 1'b1, 16'h00A6, 3'd2};
    vecs[10] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 16'h0016, 16'h00A6, 1'b0, 16'h0000, 3'd1};
    vecs[11] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 3'd0};
    // Youngest-match forwarding; same-cycle store invisible; acked head still forwards
    vecs[12] = '{1'b1, 16'h0020, 16'h1111, 1'b0, 16'h0020, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 3'd0};
    vecs[13] = '{1'b1, 16'h0020, 16'h2222, 1'b0, 16'h0020, 1'b1, 1'b1, 16'h0020, 16'h1111, 1'b1, 16'h1111, 3'd1};
    vecs[14] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0020, 1'b1, 1'b1, 16'h0020, 16'h1111, 1'b1, 16'h2222, 3'd2};
    vecs[15] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0020, 1'b1, 1'b1, 16'h0020, 16'h2222, 1'b1, 16'h2222, 3'd1};
    vecs[16] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0021, 1'b1, 1'b1, 16'h0020, 16'h2222, 1'b0, 16'h0000, 3'd1};
    vecs[17] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 3'd0};
    // Seven stores so far: older 0x0030 lands in slot 3, younger in slot 0
    vecs[18] = '{1'b1, 16'h0030, 16'h0001, 1'b0, 16'h0030, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 3'd0};
    vecs[19] = '{1'b1, 16'h0030, 16'h0002, 1'b0, 16'h0030, 1'b1, 1'b1, 16'h0030, 16'h0001, 1'b1, 16'h0001, 3'd1};
    vecs[20] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0030, 1'b1, 1'b1, 16'h0030, 16'h0001, 1'b1, 16'h0002, 3'd2};
    vecs[21] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0030, 1'b1, 1'b1, 16'h0030, 16'h0001, 1'b1, 16'h0002, 3'd2};
    vecs[22] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0030, 1'b1, 1'b1, 16'h0030, 16'h0002, 1'b1, 16'h0002, 3'd1};
    vecs[23] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0030, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 3'd0};

    // ---- Reset state ----
    reset = 1'b1;
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    #1;
    check("rst stReady", 32'(bus.stReady), 32'd1);
    check("rst memReq",  32'(bus.memReq),  32'd0);
    check("rst empty",   32'(bus.empty),   32'd1);
    check("rst count",   32'(bus.count),   32'd0);
    check("rst ldHit",   32'(bus.ldHit),   32'd0);
    check("rst memAddr", 32'(bus.memAddress), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // ---- Table-driven vectors ----
    for (int i = 0; i < NVEC; i++) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i].st_valid, vecs[i].st_addr, vecs[i].st_data,
            vecs[i].ack, vecs[i].ld_addr);
      #1;
      check($sformatf("v%0d stReady", i), 32'(bus.stReady),      32'(vecs[i].ready));
      check($sformatf("v%0d memReq", i),  32'(bus.memReq),       32'(vecs[i].req));
      check($sformatf("v%0d memAddr", i), 32'(bus.memAddress),   32'(vecs[i].maddr));
      check($sformatf("v%0d memData", i), 32'(bus.memWriteData), 32'(vecs[i].mdata));
      check($sformatf("v%0d ldHit", i),   32'(bus.ldHit),        32'(vecs[i].hit));
      check($sformatf("v%0d ldData", i),  32'(bus.ldData),       32'(vecs[i].ldata));
      check($sformatf("v%0d count", i),   32'(bus.count),        32'(vecs[i].count));
      check($sformatf("v%0d empty", i),   32'(bus.empty),        32'(vecs[i].count == 3'd0));
    end

    // ---- Asynchronous reset mid-cycle with two pending entries ----
    @(negedge clk);
    drive(1'b1, 16'h0050, 16'h5555, 1'b0, 16'h0050);
    @(negedge clk);
    drive(1'b1, 16'h0051, 16'h5556, 1'b0, 16'h0050);
    @(negedge clk);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0050);
    #1;
    check("pre-rst memReq", 32'(bus.memReq), 32'd1);
    check("pre-rst count",  32'(bus.count),  32'd2);
    check("pre-rst ldHit",  32'(bus.ldHit),  32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("async memReq",  32'(bus.memReq),       32'd0);
    check("async count",   32'(bus.count),        32'd0);
    check("async ldHit",   32'(bus.ldHit),        32'd0);
    check("async ldData",  32'(bus.ldData),       32'd0);
    check("async empty",   32'(bus.empty),        32'd1);
    check("async stReady", 32'(bus.stReady),      32'd1);
    check("async memData", 32'(bus.memWriteData), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post-rst empty", 32'(bus.empty), 32'd1);
    drive(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000);
    @(negedge clk);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    #1;
    check("post-rst ack count",  32'(bus.count),  32'd0);
    check("post-rst ack memReq", 32'(bus.memReq), 32'd0);

    // ---- Spurious acks while empty must not move pointers ----
    drive(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000);
    repeat (3) @(negedge clk);
    #1;
    check("spur count", 32'(bus.count), 32'd0);
    check("spur empty", 32'(bus.empty), 32'd1);
    drive(1'b1, 16'h0040, 16'h0BEE, 1'b0, 16'h0040);
    @(negedge clk);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0040);
    #1;
    check("spur memReq",  32'(bus.memReq),       32'd1);
    check("spur memAddr", 32'(bus.memAddress),   32'h0040);
    check("spur memData", 32'(bus.memWriteData), 32'h0BEE);
    check("spur count1",  32'(bus.count),        32'd1);
    check("spur ldData",  32'(bus.ldData),       32'h0BEE);
    drive(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0040);
    @(negedge clk);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0040);
    #1;
    check("drain empty", 32'(bus.empty), 32'd1);
    check("drain ldHit", 32'(bus.ldHit), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
